// File: rtl/reorder_buffer_pkg.sv
// Shared constants and the issue_kind encoding for the reorder buffer.
package reorder_buffer_pkg;

   localparam int ROB_WIDTH     = 8;
   localparam int ROB_WIDTH_BIT = 3;
   localparam int REG_ID_BIT    = 5;

   localparam logic [ROB_WIDTH_BIT:0] ROB_COUNT_FULL =
      (ROB_WIDTH_BIT + 1)'(ROB_WIDTH);

   typedef enum logic [1:0] {
      KIND_REG    = 2'd0,
      KIND_BRANCH = 2'd1,
      KIND_JALR   = 2'd2,
      KIND_NODEST = 2'd3
   } kind_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement queue: tag allocation, result capture,
// operand forwarding, in-order commit and mispredict flush.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   output logic                     rob_full,
   input  logic                     issue_valid,
   input  logic [1:0]               issue_kind,
   input  logic [REG_ID_BIT-1:0]    issue_rd,
   input  logic                     issue_pred,
   input  logic [31:0]              issue_alt_pc,
   output logic [ROB_WIDTH_BIT-1:0] issue_tag,
   input  logic                     wb_valid,
   input  logic [ROB_WIDTH_BIT-1:0] wb_tag,
   input  logic [31:0]              wb_value,
   input  logic [31:0]              wb_new_pc,
   input  logic [ROB_WIDTH_BIT-1:0] qj_tag,
   input  logic [ROB_WIDTH_BIT-1:0] qk_tag,
   output logic                     qj_ready,
   output logic                     qk_ready,
   output logic [31:0]              qj_value,
   output logic [31:0]              qk_value,
   output logic                     commit_valid,
   output logic [REG_ID_BIT-1:0]    commit_rd,
   output logic [31:0]              commit_value,
   output logic [ROB_WIDTH_BIT-1:0] commit_tag,
   output logic                     flush,
   output logic [31:0]              flush_pc
);

   localparam logic [ROB_WIDTH_BIT-1:0] PTR_ONE = 1;
   localparam logic [ROB_WIDTH_BIT:0]   CNT_ONE = 1;

   logic [ROB_WIDTH_BIT-1:0] head;
   logic [ROB_WIDTH_BIT-1:0] tail;
   logic [ROB_WIDTH_BIT:0]   count;
   logic [ROB_WIDTH-1:0]     busy;
   logic [ROB_WIDTH-1:0]     ready;
   logic [ROB_WIDTH-1:0]     pred;
   kind_t                    kind   [ROB_WIDTH];
   logic [REG_ID_BIT-1:0]    rd     [ROB_WIDTH];
   logic [31:0]              value  [ROB_WIDTH];
   logic [31:0]              alt_pc [ROB_WIDTH];

   logic issue_ok;
   logic commit_ok;
   logic head_redirect;
   logic head_writes_reg;

   assign rob_full  = (count == ROB_COUNT_FULL);
   assign issue_tag = tail;
   assign issue_ok  = issue_valid && !rob_full;
   assign commit_ok = busy[head] && ready[head];

   assign head_redirect =
      (kind[head] == KIND_JALR) ||
      ((kind[head] == KIND_BRANCH) && (value[head][0] != pred[head]));
   assign head_writes_reg =
      (kind[head] == KIND_REG) || (kind[head] == KIND_JALR);

   // Both operand ports: stored value first, then same-cycle bypass.
   always_comb begin
      qj_ready = 1'b0;
      qj_value = '0;
      qk_ready = 1'b0;
      qk_value = '0;
      if (ready[qj_tag]) begin
         qj_ready = 1'b1;
         qj_value = value[qj_tag];
      end else if (wb_valid && wb_tag == qj_tag) begin
         qj_ready = 1'b1;
         qj_value = wb_value;
      end
      if (ready[qk_tag]) begin
         qk_ready = 1'b1;
         qk_value = value[qk_tag];
      end else if (wb_valid && wb_tag == qk_tag) begin
         qk_ready = 1'b1;
         qk_value = wb_value;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         busy         <= '0;
         ready        <= '0;
         pred         <= '0;
         commit_valid <= 1'b0;
         commit_rd    <= '0;
         commit_value <= '0;
         commit_tag   <= '0;
         flush        <= 1'b0;
         flush_pc     <= '0;
         for (int i = 0; i < ROB_WIDTH; i++) begin
            kind[i]   <= KIND_REG;
            rd[i]     <= '0;
            value[i]  <= '0;
            alt_pc[i] <= '0;
         end
      end else if (flush) begin
         // Flush completes on the edge ending its pulse, even if paused.
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         busy         <= '0;
         ready        <= '0;
         commit_valid <= 1'b0;
         flush        <= 1'b0;
      end else if (!rdy_in) begin
         commit_valid <= 1'b0;
         flush        <= 1'b0;
      end else begin
         commit_valid <= commit_ok;
         flush        <= 1'b0;
         if (issue_ok) begin
            busy[tail]   <= 1'b1;
            ready[tail]  <= 1'b0;
            kind[tail]   <= kind_t'(issue_kind);
            rd[tail]     <= issue_rd;
            pred[tail]   <= issue_pred;
            alt_pc[tail] <= issue_alt_pc;
            tail         <= tail + PTR_ONE;
         end
         if (wb_valid && busy[wb_tag]) begin
            value[wb_tag] <= wb_value;
            ready[wb_tag] <= 1'b1;
            if (kind[wb_tag] == KIND_JALR)
               alt_pc[wb_tag] <= wb_new_pc;
         end
         if (commit_ok) begin
            busy[head]   <= 1'b0;
            ready[head]  <= 1'b0;
            head         <= head + PTR_ONE;
            commit_tag   <= head;
            commit_value <= value[head];
            commit_rd    <= head_writes_reg ? rd[head] : '0;
            if (head_redirect) begin
               flush    <= 1'b1;
               flush_pc <= alt_pc[head];
            end
         end
         unique case ({issue_ok, commit_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill/drain, bypass, branch,
// jalr, wrap, pause and asynchronous reset.
module tb_reorder_buffer;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        rob_full;
   logic        issue_valid = 1'b0;
   logic [1:0]  issue_kind = '0;
   logic [4:0]  issue_rd = '0;
   logic        issue_pred = 1'b0;
   logic [31:0] issue_alt_pc = '0;
   logic [2:0]  issue_tag;
   logic        wb_valid = 1'b0;
   logic [2:0]  wb_tag = '0;
   logic [31:0] wb_value = '0;
   logic [31:0] wb_new_pc = '0;
   logic [2:0]  qj_tag = '0;
   logic [2:0]  qk_tag = '0;
   logic        qj_ready;
   logic        qk_ready;
   logic [31:0] qj_value;
   logic [31:0] qk_value;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [31:0] commit_value;
   logic [2:0]  commit_tag;
   logic        flush;
   logic [31:0] flush_pc;

   int n_vec = 0;
   int n_bad = 0;

   reorder_buffer dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .rob_full     (rob_full),
      .issue_valid  (issue_valid),
      .issue_kind   (issue_kind),
      .issue_rd     (issue_rd),
      .issue_pred   (issue_pred),
      .issue_alt_pc (issue_alt_pc),
      .issue_tag    (issue_tag),
      .wb_valid     (wb_valid),
      .wb_tag       (wb_tag),
      .wb_value     (wb_value),
      .wb_new_pc    (wb_new_pc),
      .qj_tag       (qj_tag),
      .qk_tag       (qk_tag),
      .qj_ready     (qj_ready),
      .qk_ready     (qk_ready),
      .qj_value     (qj_value),
      .qk_value     (qk_value),
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .commit_value (commit_value),
      .commit_tag   (commit_tag),
      .flush        (flush),
      .flush_pc     (flush_pc)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_issue(input logic [1:0] k, input logic [4:0] r,
                           input logic p, input logic [31:0] a);
      issue_valid  = 1'b1;
      issue_kind   = k;
      issue_rd     = r;
      issue_pred   = p;
      issue_alt_pc = a;
      tick();
      issue_valid  = 1'b0;
   endtask

   task automatic do_wb(input logic [2:0] t, input logic [31:0] v,
                        input logic [31:0] npc);
      wb_valid  = 1'b1;
      wb_tag    = t;
      wb_value  = v;
      wb_new_pc = npc;
      tick();
      wb_valid  = 1'b0;
   endtask

   initial begin
      #1;
      check("rst_full", 32'(rob_full), 32'd0);
      check("rst_cvalid", 32'(commit_valid), 32'd0);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_itag", 32'(issue_tag), 32'd0);
      check("rst_cval", commit_value, 32'd0);
      check("rst_fpc", flush_pc, 32'd0);
      tick();
      rst_in = 1'b0;
      tick();

      // fill with 8 kind-0 entries, no writeback
      for (int i = 0; i < 8; i++) begin
         check("fill_tag", 32'(issue_tag), 32'(i));
         check("fill_full", 32'(rob_full), 32'd0);
         do_issue(2'd0, 5'(i + 1), 1'b0, 32'h0);
      end
      check("full", 32'(rob_full), 32'd1);
      do_issue(2'd0, 5'd30, 1'b0, 32'h0);
      check("ninth_rej", 32'(rob_full), 32'd1);
      for (int t = 7; t >= 1; t--) begin
         do_wb(3'(t), 32'h100 + 32'(t), 32'h0);
         check("no_early_commit", 32'(commit_valid), 32'd0);
      end
      do_wb(3'd0, 32'h100, 32'h0);
      check("wb0_lat", 32'(commit_valid), 32'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("drain_valid", 32'(commit_valid), 32'd1);
         check("drain_tag", 32'(commit_tag), 32'(k));
         check("drain_rd", 32'(commit_rd), 32'(k + 1));
         check("drain_val", commit_value, 32'h100 + 32'(k));
      end
      tick();
      check("drain_done", 32'(commit_valid), 32'd0);
      check("drain_full", 32'(rob_full), 32'd0);

      // same-cycle bypass on tag 0
      check("byp_itag", 32'(issue_tag), 32'd0);
      do_issue(2'd0, 5'd9, 1'b0, 32'h0);
      wb_valid = 1'b1;
      wb_tag   = 3'd0;
      wb_value = 32'h1234;
      qj_tag   = 3'd0;
      qk_tag   = 3'd1;
      #1;
      check("byp_rdy", 32'(qj_ready), 32'd1);
      check("byp_val", qj_value, 32'h1234);
      check("byp_k_nrdy", 32'(qk_ready), 32'd0);
      tick();
      wb_valid = 1'b0;
      #1;
      check("stored_rdy", 32'(qj_ready), 32'd1);
      check("stored_val", qj_value, 32'h1234);
      tick();
      check("byp_commit", 32'(commit_valid), 32'd1);
      check("byp_cval", commit_value, 32'h1234);
      check("byp_crd", 32'(commit_rd), 32'd9);

      // correctly predicted branch, tag 1
      do_issue(2'd1, 5'd7, 1'b1, 32'h300);
      do_wb(3'd1, 32'h1, 32'h0);
      tick();
      check("br_ok_valid", 32'(commit_valid), 32'd1);
      check("br_ok_flush", 32'(flush), 32'd0);
      check("br_ok_rd", 32'(commit_rd), 32'd0);

      // mispredicted branch tag 2 with younger 3..5
      do_issue(2'd1, 5'd0, 1'b1, 32'h100);
      do_issue(2'd0, 5'd3, 1'b0, 32'h0);
      do_issue(2'd0, 5'd4, 1'b0, 32'h0);
      do_issue(2'd3, 5'd5, 1'b0, 32'h0);
      do_wb(3'd3, 32'h55, 32'h0);
      do_wb(3'd2, 32'h0, 32'h0);
      check("mp_wait", 32'(commit_valid), 32'd0);
      tick();
      check("mp_valid", 32'(commit_valid), 32'd1);
      check("mp_tag", 32'(commit_tag), 32'd2);
      check("mp_flush", 32'(flush), 32'd1);
      check("mp_pc", flush_pc, 32'h100);
      tick();
      check("mp_flush_end", 32'(flush), 32'd0);
      check("mp_no_commit", 32'(commit_valid), 32'd0);
      check("mp_itag", 32'(issue_tag), 32'd0);
      check("mp_full", 32'(rob_full), 32'd0);

      // jalr at tag 0
      do_issue(2'd2, 5'd1, 1'b0, 32'h0);
      do_wb(3'd0, 32'h44, 32'h200);
      tick();
      check("jalr_valid", 32'(commit_valid), 32'd1);
      check("jalr_rd", 32'(commit_rd), 32'd1);
      check("jalr_val", commit_value, 32'h44);
      check("jalr_flush", 32'(flush), 32'd1);
      check("jalr_pc", flush_pc, 32'h200);
      tick();
      check("jalr_itag", 32'(issue_tag), 32'd0);

      // 20 issue/commit pairs, pointers wrap twice
      for (int i = 0; i < 20; i++) begin
         check("wrap_itag", 32'(issue_tag), 32'(i % 8));
         do_issue(2'd0, 5'(i + 1), 1'b0, 32'h0);
         do_wb(3'(i % 8), 32'h1000 + 32'(i), 32'h0);
         tick();
         check("wrap_ctag", 32'(commit_tag), 32'(i % 8));
         check("wrap_cval", commit_value, 32'h1000 + 32'(i));
      end

      // pause with a ready head at tag 4
      do_issue(2'd0, 5'd12, 1'b0, 32'h0);
      do_wb(3'd4, 32'hbeef, 32'h0);
      rdy_in = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("pause_hold", 32'(commit_valid), 32'd0);
      end
      rdy_in = 1'b1;
      tick();
      check("pause_commit", 32'(commit_valid), 32'd1);
      check("pause_tag", 32'(commit_tag), 32'd4);
      check("pause_val", commit_value, 32'hbeef);

      // asynchronous reset between edges
      do_issue(2'd0, 5'd3, 1'b0, 32'h0);
      do_issue(2'd0, 5'd4, 1'b0, 32'h0);
      do_wb(3'd5, 32'habcd, 32'h0);
      tick();
      check("pre_rst_valid", 32'(commit_valid), 32'd1);
      check("pre_rst_val", commit_value, 32'habcd);
      #2;
      rst_in = 1'b1;
      #1;
      check("arst_valid", 32'(commit_valid), 32'd0);
      check("arst_val", commit_value, 32'd0);
      check("arst_tag", 32'(commit_tag), 32'd0);
      check("arst_itag", 32'(issue_tag), 32'd0);
      tick();
      rst_in = 1'b0;
      tick();
      check("post_rst_valid", 32'(commit_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
